// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared types and helpers for the FIFO write arbiter and its round-robin picker.
package fifo_arb_pkg;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } arb_state_e;

  localparam int STAT_W = 16;

  // Ceiling log2, used to validate the channel-tag width against the channel count.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Rotate-priority encoder: first set bit of req scanning upward from ptr, with wrap.
module rr_pick #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [W-1:0] idx,
  output logic         found
);

  // Scan offsets from farthest to nearest so the nearest valid request wins.
  always_comb begin
    int c;
    c     = 0;
    idx   = '0;
    found = |req;
    for (int k = N - 1; k >= 0; k--) begin
      c = int'(ptr) + k;
      if (c >= N) c = c - N;
      if (req[c]) idx = W'(c);
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter sharing one FIFO write port among NUM_REQ channels.
// Optional per-channel beat counters are built when FIFO_ARB_STATS_EN is defined.
// Reset drops any grant combinationally so no beat is written in the reset cycle.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int DATA_W    = 64,
  parameter int MAX_BURST = 8,
  parameter int ID_W      = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ-1:0]        req_last,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic                      fifo_full,
  output logic                      fifo_wr_en,
  output logic [ID_W+DATA_W-1:0]    fifo_din,
  output logic [ID_W-1:0]           grant_id,
  output logic                      busy,
  input  logic                      stats_clr,
  output logic [NUM_REQ*STAT_W-1:0] beat_cnt
);

  if (ID_W != clog2(NUM_REQ)) begin : g_id_w_chk
    $error("fifo_wr_arbiter: ID_W must equal clog2(NUM_REQ)");
  end

  arb_state_e      state_q, state_d;
  logic [ID_W-1:0] grant_id_q, grant_id_d;
  logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [7:0]      burst_cnt_q, burst_cnt_d;

  logic [ID_W-1:0]   pick_idx;
  logic              pick_found;
  logic              in_grant;
  logic              gnt_valid;
  logic              gnt_last;
  logic              beat;
  logic [DATA_W-1:0] gnt_data;
  logic [ID_W-1:0]   next_ptr;

  rr_pick #(
    .N(NUM_REQ),
    .W(ID_W)
  ) u_rr_pick (
    .req  (req_valid),
    .ptr  (rr_ptr_q),
    .idx  (pick_idx),
    .found(pick_found)
  );

  assign in_grant  = rst_n && (state_q == ST_GRANT);
  assign gnt_valid = req_valid[grant_id_q];
  assign gnt_last  = req_last[grant_id_q];
  assign gnt_data  = req_data[int'(grant_id_q)*DATA_W +: DATA_W];
  assign beat      = in_grant && gnt_valid && !fifo_full;
  assign next_ptr  = (grant_id_q == ID_W'(NUM_REQ - 1)) ? '0 : grant_id_q + 1'b1;

  // Datapath outputs: ready and write strobe follow the granted channel combinationally.
  always_comb begin
    req_ready  = '0;
    fifo_wr_en = beat;
    fifo_din   = '0;
    grant_id   = grant_id_q;
    busy       = in_grant;
    if (in_grant && !fifo_full) req_ready[grant_id_q] = 1'b1;
    if (beat) fifo_din = {grant_id_q, gnt_data};
  end

  // Next-state: pick a winner in IDLE, count beats and decide release in GRANT.
  always_comb begin
    state_d     = state_q;
    grant_id_d  = grant_id_q;
    rr_ptr_d    = rr_ptr_q;
    burst_cnt_d = burst_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_found) begin
          grant_id_d  = pick_idx;
          burst_cnt_d = '0;
          state_d     = ST_GRANT;
        end
      end
      ST_GRANT: begin
        if (beat) burst_cnt_d = burst_cnt_q + 8'd1;
        if ((beat && (gnt_last || (burst_cnt_q + 8'd1 == 8'(MAX_BURST)))) ||
            (!gnt_valid && !fifo_full)) begin
          state_d  = ST_IDLE;
          rr_ptr_d = next_ptr;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Control state registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      grant_id_q  <= '0;
      rr_ptr_q    <= '0;
      burst_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      grant_id_q  <= grant_id_d;
      rr_ptr_q    <= rr_ptr_d;
      burst_cnt_q <= burst_cnt_d;
    end
  end

`ifdef FIFO_ARB_STATS_EN
  logic [NUM_REQ-1:0][STAT_W-1:0] beat_cnt_q, beat_cnt_d;

  // Saturating per-channel beat counters; clear wins over a same-cycle increment.
  always_comb begin
    beat_cnt_d = beat_cnt_q;
    if (stats_clr) begin
      beat_cnt_d = '0;
    end else if (beat && (beat_cnt_q[grant_id_q] != {STAT_W{1'b1}})) begin
      beat_cnt_d[grant_id_q] = beat_cnt_q[grant_id_q] + 1'b1;
    end
  end

  // Counter registers.
  always_ff @(posedge clk) begin
    if (!rst_n) beat_cnt_q <= '0;
    else        beat_cnt_q <= beat_cnt_d;
  end

  assign beat_cnt = beat_cnt_q;
`else
  logic unused_stats_clr;
  assign unused_stats_clr = stats_clr;
  assign beat_cnt         = '0;
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
module tb_fifo_wr_arbiter;

  localparam int N  = 4;
  localparam int DW = 64;
  localparam int MB = 8;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    req_valid, req_last, req_ready;
  logic [N*DW-1:0] req_data;
  logic            fifo_full, fifo_wr_en, busy, stats_clr;
  logic [DW+1:0]   fifo_din;
  logic [1:0]      grant_id;
  logic [N*16-1:0] beat_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  fifo_wr_arbiter #(.NUM_REQ(N), .DATA_W(DW), .MAX_BURST(MB), .ID_W(2)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_last(req_last),
    .req_data(req_data), .req_ready(req_ready), .fifo_full(fifo_full),
    .fifo_wr_en(fifo_wr_en), .fifo_din(fifo_din), .grant_id(grant_id),
    .busy(busy), .stats_clr(stats_clr), .beat_cnt(beat_cnt)
  );

  typedef struct {
    logic [3:0]  v;
    logic [3:0]  l;
    logic        f;
    logic [63:0] d;
    logic [3:0]  e_rdy;
    logic        e_wr;
    logic [1:0]  e_gid;
    logic        e_busy;
  } vec_t;

  vec_t tbl[$];

  function automatic logic [63:0] cdata(input logic [63:0] base, input int ch);
    return base + (64'(ch) << 56);
  endfunction

  function automatic logic [65:0] ed(input logic wr, input logic [1:0] g, input logic [63:0] base);
    return wr ? {g, cdata(base, int'(g))} : 66'd0;
  endfunction

  function automatic logic [127:0] pk(input logic [3:0] rdy, input logic wr, input logic [65:0] din,
                                      input logic [1:0] gid, input logic b);
    return {54'd0, rdy, wr, din, gid, b};
  endfunction

  function automatic vec_t mk(input logic [3:0] v, input logic [3:0] l, input logic f,
                              input logic [63:0] d, input logic [3:0] e_rdy, input logic e_wr,
                              input logic [1:0] e_gid, input logic e_busy);
    vec_t t;
    t.v = v; t.l = l; t.f = f; t.d = d;
    t.e_rdy = e_rdy; t.e_wr = e_wr; t.e_gid = e_gid; t.e_busy = e_busy;
    return t;
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic set_data(input logic [63:0] base);
    for (int i = 0; i < N; i++) req_data[i*DW +: DW] = cdata(base, i);
  endtask

  function automatic logic [127:0] act_out();
    return pk(req_ready, fifo_wr_en, fifo_din, grant_id, busy);
  endfunction

  task automatic step(input logic [3:0] v, input logic [3:0] l, input logic f, input logic [63:0] base);
    @(negedge clk);
    req_valid = v; req_last = l; fifo_full = f; set_data(base);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; req_valid = '0; req_last = '0; fifo_full = 1'b0; stats_clr = 1'b0; set_data('0);
    @(negedge clk);
    #1;
    chk("reset_out", act_out(), pk(4'd0, 1'b0, 66'd0, 2'd0, 1'b0));
    chk("reset_bc", 128'(beat_cnt), 128'd0);
    rst_n = 1'b1;
  endtask

  // Reference model state (abstract: holder flag, holder channel, beats taken, next start)
  bit m_act;
  int m_gid, m_cnt, m_ptr;
  int m_bc[N];

  task automatic model_reset();
    m_act = 0; m_gid = 0; m_cnt = 0; m_ptr = 0;
    for (int i = 0; i < N; i++) m_bc[i] = 0;
  endtask

  initial begin
    logic [63:0] base, seq;
    logic [3:0]  e_rdy;
    logic        e_wr, e_busy;
    logic [1:0]  e_gid;
    logic [63:0] e_bc;
    int          nb;

    rst_n = 1'b0; req_valid = '0; req_last = '0; fifo_full = 1'b0; stats_clr = 1'b0; req_data = '0;

    // ---- table: single channel two 3-beat bursts, then a full-at-grant case ----
    tbl.push_back(mk(4'b0001, 4'b0000, 0, 64'h0,  4'b0000, 0, 2'd0, 0));
    tbl.push_back(mk(4'b0001, 4'b0000, 0, 64'hA1, 4'b0001, 1, 2'd0, 1));
    tbl.push_back(mk(4'b0001, 4'b0000, 0, 64'hA2, 4'b0001, 1, 2'd0, 1));
    tbl.push_back(mk(4'b0001, 4'b0001, 0, 64'hA3, 4'b0001, 1, 2'd0, 1));
    tbl.push_back(mk(4'b0001, 4'b0000, 0, 64'h0,  4'b0000, 0, 2'd0, 0));
    tbl.push_back(mk(4'b0001, 4'b0000, 0, 64'hB1, 4'b0001, 1, 2'd0, 1));
    tbl.push_back(mk(4'b0001, 4'b0000, 0, 64'hB2, 4'b0001, 1, 2'd0, 1));
    tbl.push_back(mk(4'b0001, 4'b0001, 0, 64'hB3, 4'b0001, 1, 2'd0, 1));
    tbl.push_back(mk(4'b0000, 4'b0000, 0, 64'h0,  4'b0000, 0, 2'd0, 0));
    tbl.push_back(mk(4'b0100, 4'b0000, 1, 64'h0,  4'b0000, 0, 2'd0, 0));
    tbl.push_back(mk(4'b0100, 4'b0000, 1, 64'hC1, 4'b0000, 0, 2'd2, 1));
    tbl.push_back(mk(4'b0100, 4'b0100, 0, 64'hC2, 4'b0100, 1, 2'd2, 1));
    tbl.push_back(mk(4'b0000, 4'b0000, 0, 64'h0,  4'b0000, 0, 2'd2, 0));

    do_reset();
    foreach (tbl[i]) begin
      step(tbl[i].v, tbl[i].l, tbl[i].f, tbl[i].d);
      chk($sformatf("tbl[%0d]", i), act_out(),
          pk(tbl[i].e_rdy, tbl[i].e_wr, ed(tbl[i].e_wr, tbl[i].e_gid, tbl[i].d), tbl[i].e_gid, tbl[i].e_busy));
    end

    // ---- all channels valid, no last: rotation with MAX_BURST beats each ----
    do_reset();
    base = 64'h100;
    for (int r = 0; r < 5; r++) begin
      step(4'hF, 4'h0, 1'b0, base); base++;
      chk($sformatf("rot_bubble%0d", r), act_out(), pk(4'd0, 1'b0, 66'd0, 2'(r == 0 ? 0 : (r - 1) % N), 1'b0));
      for (int b = 0; b < MB; b++) begin
        step(4'hF, 4'h0, 1'b0, base);
        chk($sformatf("rot_g%0d_b%0d", r, b), act_out(),
            pk(4'b0001 << (r % N), 1'b1, ed(1'b1, 2'(r % N), base), 2'(r % N), 1'b1));
        base++;
      end
    end
    step(4'h0, 4'h0, 1'b0, base);
    chk("rot_end", act_out(), pk(4'd0, 1'b0, 66'd0, 2'd0, 1'b0));

    // ---- channel 1 streaming with 5 full cycles mid-burst ----
    do_reset();
    seq = 64'd0;
    step(4'b0010, 4'b0000, 1'b0, seq);
    chk("full_idle", act_out(), pk(4'd0, 1'b0, 66'd0, 2'd0, 1'b0));
    for (int b = 0; b < 2; b++) begin
      step(4'b0010, 4'b0000, 1'b0, seq);
      chk($sformatf("full_pre%0d", b), act_out(), pk(4'b0010, 1'b1, ed(1'b1, 2'd1, seq), 2'd1, 1'b1));
      seq++;
    end
    for (int b = 0; b < 5; b++) begin
      step(4'b0010, 4'b0000, 1'b1, seq);
      chk($sformatf("full_hold%0d", b), act_out(), pk(4'd0, 1'b0, 66'd0, 2'd1, 1'b1));
    end
    for (int b = 0; b < 6; b++) begin
      step(4'b0010, 4'b0000, 1'b0, seq);
      chk($sformatf("full_post%0d", b), act_out(), pk(4'b0010, 1'b1, ed(1'b1, 2'd1, seq), 2'd1, 1'b1));
      seq++;
    end
    step(4'b0010, 4'b0000, 1'b0, seq);
    chk("full_release", act_out(), pk(4'd0, 1'b0, 66'd0, 2'd1, 1'b0));

    // ---- channel 2 stalls after 2 beats; channel 3 wins next even with 0 valid ----
    do_reset();
    step(4'b1100, 4'b0000, 1'b0, 64'h20);
    chk("stall_idle", act_out(), pk(4'd0, 1'b0, 66'd0, 2'd0, 1'b0));
    for (int b = 0; b < 2; b++) begin
      step(4'b1100, 4'b0000, 1'b0, 64'h21 + 64'(b));
      chk($sformatf("stall_beat%0d", b), act_out(), pk(4'b0100, 1'b1, ed(1'b1, 2'd2, 64'h21 + 64'(b)), 2'd2, 1'b1));
    end
    step(4'b1000, 4'b0000, 1'b0, 64'h23);
    chk("stall_cycle", act_out(), pk(4'b0100, 1'b0, 66'd0, 2'd2, 1'b1));
    step(4'b1001, 4'b0000, 1'b0, 64'h24);
    chk("stall_bubble", act_out(), pk(4'd0, 1'b0, 66'd0, 2'd2, 1'b0));
    step(4'b1001, 4'b0000, 1'b0, 64'h25);
    chk("stall_next_ch3", act_out(), pk(4'b1000, 1'b1, ed(1'b1, 2'd3, 64'h25), 2'd3, 1'b1));

    // ---- reset during 4th beat of a burst ----
    do_reset();
    step(4'b0010, 4'b0010, 1'b0, 64'h30);
    step(4'b0010, 4'b0010, 1'b0, 64'h31);
    chk("rst_pre_single", act_out(), pk(4'b0010, 1'b1, ed(1'b1, 2'd1, 64'h31), 2'd1, 1'b1));
    step(4'b0100, 4'b0000, 1'b0, 64'h32);
    for (int b = 0; b < 3; b++) begin
      step(4'b0100, 4'b0000, 1'b0, 64'h33 + 64'(b));
      chk($sformatf("rst_beat%0d", b), act_out(), pk(4'b0100, 1'b1, ed(1'b1, 2'd2, 64'h33 + 64'(b)), 2'd2, 1'b1));
    end
    @(negedge clk);
    rst_n = 1'b0; req_valid = 4'b0100; set_data(64'h36);
    #1;
    chk("rst_no_4th_beat", 128'(fifo_wr_en), 128'd0);
    step(4'b0000, 4'b0000, 1'b0, 64'h37);
    rst_n = 1'b1;
    chk("rst_after_out", act_out(), pk(4'd0, 1'b0, 66'd0, 2'd0, 1'b0));
    chk("rst_after_bc", 128'(beat_cnt), 128'd0);
    step(4'b1111, 4'b0000, 1'b0, 64'h38);
    step(4'b1111, 4'b0000, 1'b0, 64'h39);
    chk("rst_ptr_zero", act_out(), pk(4'b0001, 1'b1, ed(1'b1, 2'd0, 64'h39), 2'd0, 1'b1));

    // ---- randomized run against the reference model ----
    do_reset();
    model_reset();
    for (int cyc = 0; cyc < 1500; cyc++) begin
      @(negedge clk);
      rst_n = ($urandom_range(0, 199) != 0);
      for (int i = 0; i < N; i++) begin
        req_valid[i] = ($urandom_range(0, 3) != 0);
        req_last[i]  = ($urandom_range(0, 3) == 0);
      end
      fifo_full = ($urandom_range(0, 3) == 0);
      stats_clr = ($urandom_range(0, 49) == 0);
      base = {$urandom, $urandom};
      set_data(base);
      #1;
      e_rdy = '0; e_wr = 1'b0; e_busy = 1'b0; e_gid = 2'(m_gid);
      if (rst_n && m_act) begin
        e_busy = 1'b1;
        if (!fifo_full) e_rdy[m_gid] = 1'b1;
        e_wr = req_valid[m_gid] && !fifo_full;
      end
      for (int i = 0; i < N; i++) e_bc[i*16 +: 16] = 16'(m_bc[i]);
      chk($sformatf("rnd_out%0d", cyc), act_out(), pk(e_rdy, e_wr, ed(e_wr, e_gid, base), e_gid, e_busy));
      chk($sformatf("rnd_bc%0d", cyc), 128'(beat_cnt), 128'(e_bc));
      if (!rst_n) begin
        model_reset();
      end else begin
`ifdef FIFO_ARB_STATS_EN
        if (stats_clr) begin
          for (int i = 0; i < N; i++) m_bc[i] = 0;
        end else if (e_wr && m_bc[m_gid] < 65535) begin
          m_bc[m_gid]++;
        end
`endif
        if (m_act) begin
          if (e_wr) begin
            m_cnt++;
            if (req_last[m_gid] || m_cnt == MB) begin
              m_act = 0; m_ptr = (m_gid + 1) % N;
            end
          end else if (!req_valid[m_gid] && !fifo_full) begin
            m_act = 0; m_ptr = (m_gid + 1) % N;
          end
        end else begin
          for (int k = N - 1; k >= 0; k--) begin
            if (req_valid[(m_ptr + k) % N]) begin
              m_gid = (m_ptr + k) % N; m_act = 1;
            end
          end
          m_cnt = 0;
        end
      end
    end
    stats_clr = 1'b0;

`ifdef FIFO_ARB_STATS_EN
    // ---- counter saturation and clear ----
    do_reset();
    nb = 0;
    for (int cyc = 0; cyc < 80000 && nb < 70000; cyc++) begin
      step(4'b0001, 4'b0000, 1'b0, 64'(cyc));
      if (fifo_wr_en) nb++;
    end
    chk("sat_beats_seen", 128'(nb), 128'd70000);
    step(4'b0000, 4'b0000, 1'b0, 64'h0);
    chk("sat_value", 128'(beat_cnt), 128'h0000_0000_0000_FFFF);
    stats_clr = 1'b1;
    step(4'b0000, 4'b0000, 1'b0, 64'h0);
    stats_clr = 1'b0;
    step(4'b0000, 4'b0000, 1'b0, 64'h0);
    chk("sat_cleared", 128'(beat_cnt), 128'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Round-robin write arbiter that shares one downstream FIFO write port among NUM_REQ producer channels, such as per-layer DMA readers or PE result collectors. Each channel presents valid/ready streams with burst framing. The arbiter grants one channel at a time, forwards its beats to the FIFO tagged with the channel ID, and respects FIFO backpressure. It sits directly in front of the shared FIFO on the accelerator datapath.

## Interface
- NUM_REQ, 4: number of requesting channels (2..16).
- DATA_W, 64: payload width per beat.
- MAX_BURST, 8: maximum beats per grant before forced rotation (1..255).
- ID_W, 2: channel tag width, equal to clog2(NUM_REQ).
- clk  in  1  clock, all logic on the rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- req_valid  in  NUM_REQ  per-channel beat valid.
- req_last  in  NUM_REQ  per-channel end-of-burst marker.
- req_data  in  NUM_REQ*DATA_W  channel i occupies bits [i*DATA_W +: DATA_W].
- req_ready  out  NUM_REQ  per-channel beat accept.
- fifo_full  in  1  downstream FIFO full flag.
- fifo_wr_en  out  1  downstream write strobe.
- fifo_din  out  ID_W+DATA_W  holds {grant_id, payload}.
- grant_id  out  ID_W  currently or last granted channel.
- busy  out  1  high while in GRANT.
- stats_clr  in  1  clears the beat counters.
- beat_cnt  out  NUM_REQ*16  per-channel accepted-beat counters.

## Operation
- FSM has two states, IDLE and GRANT. It resets to IDLE.
- IDLE: if any req_valid is high, pick the first valid channel scanning upward from rr_ptr, with wrap-around. Register it into grant_id, clear burst_cnt, and go to GRANT. If no channel is valid, stay in IDLE.
- GRANT:
  - req_ready[grant_id] = ~fifo_full. All other req_ready bits are 0.
  - A beat occurs when req_valid[grant_id] and ~fifo_full are both high.
  - On a beat: fifo_wr_en=1, fifo_din={grant_id, req_data[grant_id]}, and burst_cnt increments.
- Release from GRANT to IDLE, with rr_ptr = (grant_id+1) mod NUM_REQ, on any of:
  - a beat with req_last high;
  - a beat that makes burst_cnt equal MAX_BURST;
  - a cycle where req_valid[grant_id]=0 and fifo_full=0 (producer stalled).
- fifo_full high in GRANT: hold the grant, keep req_ready low, no beat, burst_cnt unchanged. Full does not by itself cause release.
- Arithmetic:
  - burst_cnt is 8 bits.
  - rr_ptr wraps modulo NUM_REQ, including non-power-of-two NUM_REQ.
  - The ID tag is the channel index, zero-extended to ID_W.
- Reset mid-burst: the grant is dropped immediately and no further beats are written. Upstream retransmission is the producer's responsibility.

## Timing
- Reset values: fifo_wr_en=0, req_ready=0, fifo_din=0, grant_id=0, busy=0, rr_ptr=0, beat_cnt=0.
- Grant latency: 1 cycle from req_valid seen in IDLE to req_ready asserted.
- Write path is combinational: fifo_wr_en and fifo_din follow the accepted beat in the same cycle. The FIFO captures the beat on that edge.
- Bubble: exactly one IDLE cycle between consecutive bursts. Peak throughput is MAX_BURST/(MAX_BURST+1).
- fifo_full is sampled in the same cycle. A beat is never issued while fifo_full=1.
- busy is high during every GRANT cycle and low in IDLE.

## Configuration
- Macro: FIFO_ARB_STATS_EN.
- Defined:
  - beat_cnt holds one 16-bit counter per channel, incremented on each beat of that channel.
  - Counters saturate at 16'hFFFF.
  - stats_clr zeroes all counters synchronously and takes priority over a same-cycle increment.
- Undefined: beat_cnt is tied to 0, stats_clr is ignored, and no counter flops are built. Ports are kept for interface stability.

## Structure
- Package fifo_arb_pkg holds:
  - the state encoding (ST_IDLE, ST_GRANT);
  - the constant STAT_W=16;
  - a clog2 function used for ID_W checks.
- Sub-module rr_pick: combinational rotate-priority encoder. Inputs are the req vector and rr_ptr. Outputs are the winner index and a found flag. It is reusable by other arbiters.

## Test plan
- Single channel 2 bursts 3 beats, last on beat 3, FIFO never full -> grant 1 cycle after valid; 3 consecutive fifo_wr_en; ID tag 2'd0; one IDLE bubble; second burst identical.
- All 4 channels valid continuously, req_last never asserted, MAX_BURST=8 -> grants rotate 0,1,2,3,0; exactly 8 beats each; fifo_din upper bits match grant_id.
- Channel 1 streaming, fifo_full held high 5 cycles mid-burst -> req_ready[1]=0 and fifo_wr_en=0 for those 5 cycles; grant retained; burst_cnt resumes with no lost or duplicated data.
- Channel 2 drops req_valid after 2 beats while channel 3 is valid -> release; next grant goes to channel 3; rr_ptr=3.
- rst_n low for 1 cycle during the 4th beat of a burst -> all outputs at reset values next cycle; FSM in IDLE; rr_ptr=0.
- FIFO_ARB_STATS_EN defined; 70000 beats on channel 0, then stats_clr -> beat_cnt[0] saturates at 65535, then reads 0 the cycle after clear.
